// File: rtl/ps2_mouse_rx_if.sv
// Bus between the PS/2 receive deserialiser and its environment: the raw pad
// inputs plus the byte/strobe outputs toward the mouse master FSM.
interface ps2_mouse_rx_if;
  logic       READ_ENABLE;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output READ_ENABLE, CLK_MOUSE_IN, DATA_MOUSE_IN,
    input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );

  modport slave (
    input  READ_ENABLE, CLK_MOUSE_IN, DATA_MOUSE_IN,
    output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the mouse clock,
// shifts in 11-bit frames and strobes each byte with parity/stop error flags.
module ps2_mouse_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic CLK,
  input  logic RESET,
  ps2_mouse_rx_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          clk_flt_q, clk_flt_d;
  logic          clk_dly_q, clk_dly_d;
  logic          fall;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    byte_read_q, byte_read_d;
  logic [1:0]    err_code_q, err_code_d;

  // Two-flop synchronisers on both pad inputs.
  always_comb begin
    clk_s1_d = bus.CLK_MOUSE_IN;
    clk_s2_d = clk_s1_q;
    dat_s1_d = bus.DATA_MOUSE_IN;
    dat_s2_d = dat_s1_q;
  end

  // The filtered clock flips only after FILTER_LEN consecutive samples that
  // disagree with it; any agreeing sample restarts the run.
  always_comb begin
    flt_cnt_d = '0;
    clk_flt_d = clk_flt_q;
    clk_dly_d = clk_flt_q;
    if (clk_s2_q != clk_flt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) clk_flt_d = clk_s2_q;
      else                                  flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall = clk_dly_q & ~clk_flt_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    to_cnt_d    = '0;
    byte_read_d = byte_read_q;
    err_code_d  = err_code_q;
    unique case (state_q)
      IDLE: begin
        if (fall && bus.READ_ENABLE && !dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA, PARITY, STOP: begin
        if (!bus.READ_ENABLE) begin
          state_d = IDLE;
        end else if (fall) begin
          // FALL beats the timeout terminal count: counter stays cleared.
          unique case (state_q)
            DATA: begin
              shift_d[bit_cnt_q[2:0]] = dat_s2_q;
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) state_d = PARITY;
            end
            PARITY: begin
              par_err_d = ~(^shift_q ^ dat_s2_q);
              state_d   = STOP;
            end
            default: begin
              byte_read_d = shift_q;
              err_code_d  = {~dat_s2_q, par_err_q};
              state_d     = DONE;
            end
          endcase
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      flt_cnt_q   <= '0;
      clk_flt_q   <= 1'b1;
      clk_dly_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      to_cnt_q    <= '0;
      byte_read_q <= '0;
      err_code_q  <= '0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      flt_cnt_q   <= flt_cnt_d;
      clk_flt_q   <= clk_flt_d;
      clk_dly_q   <= clk_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      to_cnt_q    <= to_cnt_d;
      byte_read_q <= byte_read_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.BYTE_READ       = byte_read_q;
  assign bus.BYTE_ERROR_CODE = err_code_q;
  assign bus.BYTE_READY      = (state_q == DONE);

endmodule
